// File: rtl/q_seq_pkg.sv
// Shared constants for the q_seq_gen sequence generator.
// Mode encodings and the Johnson code table.
package q_seq_pkg;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_JOHN = 2'b10;

    localparam int JOHN_LEN = 6;

    // Entry 0 is the rightmost element.
    localparam logic [5:0][2:0] JOHN_CODE = {
        3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000
    };

endpackage

// File: rtl/q_seq_encode.sv
// Combinational index-to-code encoder.
// Supports binary, Gray and 6-state Johnson output codes.
module q_seq_encode
    import q_seq_pkg::*;
(
    input  logic [2:0] idx,
    input  logic [1:0] mode,
    output logic [2:0] code
);

    always_comb begin
        code = idx;
        case (mode)
            MODE_GRAY: code = idx ^ (idx >> 1);
            MODE_JOHN: code = (idx < 3'(JOHN_LEN)) ? JOHN_CODE[idx] : 3'b000;
            default:   code = idx;
        endcase
    end

endmodule

// File: rtl/q_seq_gen.sv
// Programmable-length up/down index counter with parallel load.
// Registers the encoded index onto Q3..Q1 and a wrap pulse on C.
module q_seq_gen
    import q_seq_pkg::*;
#(
    parameter int MOD     = 8,
    parameter int RST_IDX = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       En,
    input  logic       Load,
    input  logic [2:0] D,
    input  logic       Up,
    input  logic [1:0] Mode,
    output logic       Q3,
    output logic       Q2,
    output logic       Q1,
    output logic       C
);

    localparam logic [3:0] MOD_EM  = 4'(MOD);
    localparam logic [3:0] JOHN_EM = (MOD < JOHN_LEN) ? 4'(MOD) : 4'(JOHN_LEN);
    localparam logic [2:0] RST_V   = 3'(RST_IDX);

    logic [2:0] idx;
    logic [2:0] idx_next;
    logic [3:0] em;
    logic [2:0] em_m1;
    logic       wrap;
    logic [1:0] enc_mode;
    logic [2:0] code;
    logic [2:0] q_reg;
    logic       c_reg;

    always_comb begin
        em       = (Mode == MODE_JOHN) ? JOHN_EM : MOD_EM;
        em_m1    = 3'(em - 4'd1);
        idx_next = idx;
        wrap     = 1'b0;
        enc_mode = Mode;
        if (Reset) begin
            // Reset code is always the binary encoding of RST_IDX.
            idx_next = RST_V;
            enc_mode = MODE_BIN;
        end else if (Load) begin
            idx_next = ({1'b0, D} >= em) ? em_m1 : D;
        end else if (En) begin
            if (Up) begin
                if (idx >= em_m1) begin
                    idx_next = 3'd0;
                    wrap     = 1'b1;
                end else begin
                    idx_next = idx + 3'd1;
                end
            end else if (idx == 3'd0 || {1'b0, idx} >= em) begin
                idx_next = em_m1;
                wrap     = 1'b1;
            end else begin
                idx_next = idx - 3'd1;
            end
        end
    end

    q_seq_encode u_encode (
        .idx  (idx_next),
        .mode (enc_mode),
        .code (code)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx   <= RST_V;
            q_reg <= code;
            c_reg <= 1'b0;
        end else begin
            idx   <= idx_next;
            q_reg <= code;
            c_reg <= wrap;
        end
    end

    assign {Q3, Q2, Q1} = q_reg;
    assign C = c_reg;

endmodule

// File: tb/tb_q_seq_gen.sv
// Bench for q_seq_gen: MOD=8 and MOD=5 instances share stimulus.
// Both are checked against an arithmetic reference model.
module tb_q_seq_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [2:0] d = 3'd0;
    logic       up = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] qa, qb;
    logic       ca, cb;

    int vectors = 0;
    int errors = 0;

    int mods[2] = '{8, 5};
    int m_idx[2];
    int m_q[2];
    int m_c[2];

    always #5 clk = ~clk;

    q_seq_gen #(.MOD(8), .RST_IDX(0)) dut8 (
        .Clk(clk), .Reset(reset), .En(en), .Load(load), .D(d),
        .Up(up), .Mode(mode),
        .Q3(qa[2]), .Q2(qa[1]), .Q1(qa[0]), .C(ca)
    );

    q_seq_gen #(.MOD(5), .RST_IDX(0)) dut5 (
        .Clk(clk), .Reset(reset), .En(en), .Load(load), .D(d),
        .Up(up), .Mode(mode),
        .Q3(qb[2]), .Q2(qb[1]), .Q1(qb[0]), .C(cb)
    );

    function automatic int em_of(int mod, int md);
        if (md == 2) return (mod < 6) ? mod : 6;
        return mod;
    endfunction

    function automatic int enc(int i, int md);
        if (md == 1) return i ^ (i >> 1);
        if (md == 2) begin
            if (i > 5) return 0;
            if (i <= 3) return (1 << i) - 1;
            return (7 << (i - 3)) & 7;
        end
        return i;
    endfunction

    // Apply one clock of stimulus and advance the reference model.
    task automatic cyc(input logic r, input logic l, input logic e,
                       input logic u, input logic [2:0] dv,
                       input logic [1:0] m);
        int em;
        @(negedge clk);
        reset = r; load = l; en = e; up = u; d = dv; mode = m;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            em = em_of(mods[k], int'(m));
            m_c[k] = 0;
            if (r) begin
                m_idx[k] = 0;
                m_q[k] = enc(0, 0);
            end else begin
                if (l) begin
                    m_idx[k] = (int'(dv) >= em) ? em - 1 : int'(dv);
                end else if (e) begin
                    if (u) begin
                        if (m_idx[k] >= em - 1) begin
                            m_idx[k] = 0; m_c[k] = 1;
                        end else m_idx[k]++;
                    end else begin
                        if (m_idx[k] == 0 || m_idx[k] >= em) begin
                            m_idx[k] = em - 1; m_c[k] = 1;
                        end else m_idx[k]--;
                    end
                end
                m_q[k] = enc(m_idx[k], int'(m));
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 1, 3'd0, 2'b00);
        vectors++;
        if ({qa, ca} !== 4'b0000 || {qb, cb} !== 4'b0000) begin
            errors++;
            $display("FAIL reset: a=%b/%b b=%b/%b want 000/0", qa, ca, qb, cb);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 3'd0, 2'b00);
            vectors++;
            if ({qa, ca} !== 4'b0000 || {qb, cb} !== 4'b0000) begin
                errors++;
                $display("FAIL hold%0d: a=%b/%b b=%b/%b want 000/0", i, qa, ca, qb, cb);
            end
        end
    endtask

    task automatic test_bin_up_wrap();
        logic [2:0] eq;
        logic ec;
        cyc(1, 0, 0, 1, 3'd0, 2'b00);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 1, 3'd0, 2'b00);
            eq = 3'((i + 1) % 8);
            ec = (i == 7);
            vectors++;
            if (qa !== eq || ca !== ec) begin
                errors++;
                $display("FAIL bin_up%0d: got %b/%b want %b/%b", i, qa, ca, eq, ec);
            end
            vectors++;
            if (qb !== 3'(m_q[1]) || cb !== 1'(m_c[1])) begin
                errors++;
                $display("FAIL bin_up_m5 %0d: got %b/%b want %b/%0d", i, qb, cb, 3'(m_q[1]), m_c[1]);
            end
        end
    endtask

    task automatic test_gray_down();
        logic [2:0] exp_q[5] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
        cyc(1, 0, 0, 1, 3'd0, 2'b01);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 3'd0, 2'b01);
            vectors++;
            if (qb !== exp_q[i] || cb !== (i == 0)) begin
                errors++;
                $display("FAIL gray_down%0d: got %b/%b want %b/%b", i, qb, cb, exp_q[i], i == 0);
            end
            vectors++;
            if (qa !== 3'(m_q[0]) || ca !== 1'(m_c[0])) begin
                errors++;
                $display("FAIL gray_down_m8 %0d: got %b/%b want %b/%0d", i, qa, ca, 3'(m_q[0]), m_c[0]);
            end
        end
    endtask

    task automatic test_john_clamp();
        cyc(0, 1, 0, 1, 3'd7, 2'b10);
        vectors++;
        if (qa !== 3'b100 || ca !== 1'b0) begin
            errors++;
            $display("FAIL john_load: got %b/%b want 100/0", qa, ca);
        end
        cyc(0, 0, 1, 1, 3'd0, 2'b10);
        vectors++;
        if (qa !== 3'b000 || ca !== 1'b1) begin
            errors++;
            $display("FAIL john_wrap: got %b/%b want 000/1", qa, ca);
        end
        cyc(0, 0, 1, 1, 3'd0, 2'b10);
        vectors++;
        if (qa !== 3'b001 || ca !== 1'b0) begin
            errors++;
            $display("FAIL john_step: got %b/%b want 001/0", qa, ca);
        end
        vectors++;
        if (qb !== 3'(m_q[1]) || cb !== 1'(m_c[1])) begin
            errors++;
            $display("FAIL john_m5: got %b/%b want %b/%0d", qb, cb, 3'(m_q[1]), m_c[1]);
        end
    endtask

    task automatic test_priority();
        cyc(0, 1, 1, 1, 3'd3, 2'b00);
        vectors++;
        if (qa !== 3'b011 || ca !== 1'b0 || qb !== 3'b011 || cb !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en: a=%b/%b b=%b/%b want 011/0", qa, ca, qb, cb);
        end
        cyc(0, 0, 1, 1, 3'd0, 2'b00);
        cyc(1, 1, 1, 1, 3'd6, 2'b01);
        vectors++;
        if (qa !== 3'b000 || ca !== 1'b0 || qb !== 3'b000 || cb !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load: a=%b/%b b=%b/%b want 000/0", qa, ca, qb, cb);
        end
        // Reset on a cycle that would otherwise wrap must suppress C.
        cyc(0, 1, 0, 1, 3'd7, 2'b00);
        cyc(1, 0, 1, 1, 3'd0, 2'b00);
        vectors++;
        if (ca !== 1'b0 || qa !== 3'b000) begin
            errors++;
            $display("FAIL reset_kills_c: got %b/%b want 000/0", qa, ca);
        end
    endtask

    task automatic test_mid_switch();
        cyc(0, 1, 0, 1, 3'd7, 2'b00);
        vectors++;
        if (qa !== 3'b111) begin
            errors++;
            $display("FAIL switch_load: got %b want 111", qa);
        end
        cyc(0, 0, 0, 1, 3'd0, 2'b10);
        vectors++;
        if (qa !== 3'b000 || ca !== 1'b0) begin
            errors++;
            $display("FAIL switch_hold: got %b/%b want 000/0", qa, ca);
        end
        cyc(0, 0, 1, 1, 3'd0, 2'b10);
        vectors++;
        if (qa !== 3'b000 || ca !== 1'b1) begin
            errors++;
            $display("FAIL switch_wrap: got %b/%b want 000/1", qa, ca);
        end
        cyc(0, 0, 1, 1, 3'd0, 2'b10);
        vectors++;
        if (qa !== 3'b001 || ca !== 1'b0) begin
            errors++;
            $display("FAIL switch_step: got %b/%b want 001/0", qa, ca);
        end
    endtask

    task automatic test_random();
        logic r, l, e, u;
        logic [2:0] dv;
        logic [1:0] m;
        m = 2'b00;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            dv = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) m = 2'($urandom_range(0, 3));
            cyc(r, l, e, u, dv, m);
            for (int k = 0; k < 2; k++) begin
                logic [2:0] gq;
                logic gc;
                gq = (k == 0) ? qa : qb;
                gc = (k == 0) ? ca : cb;
                vectors++;
                if (gq !== 3'(m_q[k]) || gc !== 1'(m_c[k])) begin
                    errors++;
                    $display("FAIL rand%0d mod%0d: got %b/%b want %b/%0d",
                             i, mods[k], gq, gc, 3'(m_q[k]), m_c[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bin_up_wrap();
        test_gray_down();
        test_john_clamp();
        test_priority();
        test_mid_switch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/q_seq_gen.md
Name: q_seq_gen

Overview:
- Synchronous 3-bit sequence generator that produces the state bits Q3/Q2/Q1 and the wrap flag C.
- Drives the Q3, Q2, Q1, C inputs of the downstream state-observer stage, which is clocked on the same Clk.
- Counts a binary index modulo a programmable length, with up or down direction and parallel load.
- Encodes the index as binary, Gray or Johnson code and registers the encoded value onto Q3..Q1.

Parameters:
- MOD, 8, count length for the binary and Gray modes; legal range 2..8.
- RST_IDX, 0, index loaded on reset; must be less than MOD and less than 6.

Ports:
- Clk  input  1  system clock; every register updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable; advances the index one step per cycle.
- Load  input  1  parallel load of D into the index.
- D  input  3  load value, treated as an index (not an encoded code).
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Mode  input  2  encoding: 00 binary, 01 Gray, 10 Johnson, 11 treated as 00.
- Q3  output  1  encoded bit 2 (MSB), registered.
- Q2  output  1  encoded bit 1, registered.
- Q1  output  1  encoded bit 0 (LSB), registered.
- C  output  1  registered one-cycle pulse on wrap (carry when counting up, borrow when counting down).

Behaviour:
- Internal state is a 3-bit index `idx`. Effective modulus `EM` = MOD for binary/Gray and min(MOD,6) for Johnson; EM is evaluated from the current Mode every cycle.
- Priority on each rising edge: Reset > Load > En > hold.
- Reset: idx=RST_IDX, {Q3,Q2,Q1}=encode(RST_IDX, 00), C=0. Reset asserted mid-count discards any pending Load/En in that cycle and clears a C pulse that would otherwise be issued.
- Load: idx = (D >= EM) ? EM-1 : D. C=0. En is ignored in that cycle.
- En=1, Up=1: if idx >= EM-1, idx=0 and C=1; otherwise idx+1 and C=0.
- En=1, Up=0: if idx == 0 or idx >= EM, idx=EM-1 and C=1; otherwise idx-1 and C=0.
- En=0 with no Load: idx holds, C=0.
- Output register: {Q3,Q2,Q1} = encode(idx_next, Mode_current) every cycle, including hold cycles. A Mode change therefore appears on Q one edge later even when En=0.
- Latency: one cycle from the En/Load/Reset edge to Q and C. C is high in the same cycle that Q shows the wrapped value.
- Encodings:
  - Binary: code = idx.
  - Gray: code = idx ^ (idx>>1).
  - Johnson, idx 0..5: 000, 001, 011, 111, 110, 100. Johnson with idx >= 6 on a hold cycle encodes as 000.
- Out-of-range index after switching to a smaller EM:
  - Hold: idx is kept; Q encodes as above.
  - First enabled step: wraps, to 0 when counting up or to EM-1 when counting down, and asserts C.
- All arithmetic is 3-bit unsigned with no intermediate overflow; EM-1 is computed in 3 bits.
- C is never asserted on two consecutive cycles unless EM wraps on consecutive steps. Example: MOD=2 counting up gives C on every second cycle.

Decomposition:
- Shared package `q_seq_pkg`:
  - Mode constants MODE_BIN=2'b00, MODE_GRAY=2'b01, MODE_JOHN=2'b10.
  - JOHN_LEN=6 and the Johnson lookup constants.
- Sub-module `q_seq_encode`: purely combinational (idx[2:0], mode[1:0]) -> code[2:0]. Instantiated once, on idx_next.
- The top level holds the index register, the EM/wrap logic, and the output and C registers.

Test Plan:
- Reset then hold: assert Reset one cycle with Mode=00 -> Q=000, C=0. Hold En=0 for 5 cycles -> Q stays 000, C stays 0.
- Binary up wrap, MOD=8: En=1, Up=1 for 9 cycles -> Q goes 001,010,…,111,000,001. C=1 only in the cycle Q=000.
- Gray down borrow, MOD=5: starting from idx 0, En=1, Up=0 -> Q codes 110,010,011,001,000 (idx 4,3,2,1,0). C=1 exactly in the first cycle (the 0->4 wrap).
- Johnson with clamp, MOD=8 (EM=6):
  - Load D=7 -> idx clamps to 5, Q=100, C=0.
  - Next En up cycle -> Q=000, C=1.
  - Next cycle -> Q=001, C=0.
- Priority: same cycle Load=1 (D=3), En=1, Mode=00 -> Q=011, C=0. Same cycle Reset=1 and Load=1 -> Q=000.
- Mid-count switch, Mode 00 -> 10:
  - At idx=7, En=0 -> Q=000 (Johnson, out of range).
  - Then En=1, Up=1 -> Q=000, C=1.
  - Then Q=001.
